ysyx_23060124_axi_arbiter: RTL

Two-master, one-slave AXI4 read arbiter with write pass-through that shares the core's single memory port between the instruction fetch unit (master 0, read-only) and the load/store path of the execute unit (master 1, read/write). It sits between IFU/EXU and the SoC crossbar. The read address and read data channels are owned by exactly one master per transaction. The LSU write channels are forwarded unmodified.

---
 rtl/ysyx_23060124_axi_arbiter.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060124_axi_arbiter.sv
// Two-master AXI4 read arbiter (IFU = master 0, LSU = master 1) with LSU write pass-through.
// Define YSYX_23060124_ARB_RR_EN for round-robin on simultaneous requests; default is fixed LSU priority.
//
// state   | meaning
// IDLE    | no owner; read-path valid/ready outputs all low
// GNT_IFU | IFU owns AR and R until its RLAST handshake
// GNT_LSU | LSU owns AR and R until its RLAST handshake
module ysyx_23060124_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                i_rst,

  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ID_W-1:0]     ifu_arid,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic [1:0]          ifu_arburst,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [ID_W-1:0]     ifu_rid,
  output logic                ifu_rlast,

  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [ID_W-1:0]     lsu_arid,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  input  logic [1:0]          lsu_arburst,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [ID_W-1:0]     lsu_rid,
  output logic                lsu_rlast,

  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [7:0]          lsu_awlen,
  input  logic [2:0]          lsu_awsize,
  input  logic [1:0]          lsu_awburst,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic                lsu_wlast,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [ID_W-1:0]     lsu_bid,

  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [ID_W-1:0]     s_rid,
  input  logic                s_rlast,

  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic                s_wlast,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [ID_W-1:0]     s_bid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IFU = 2'd1,
    GNT_LSU = 2'd2
  } state_t;

  localparam logic [ID_W-1:0] ID_IFU = '0;
  localparam logic [ID_W-1:0] ID_LSU = ID_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic              ar_done;
  logic [ID_W-1:0]   rid_q;
  logic              ar_hs;
  logic              r_last_hs;
  logic              both_to_lsu;
  logic              rid_unused;

  // Routing relies on the grant register alone; the slave's RID carries no meaning here.
  assign rid_unused = ^s_rid;

  assign ar_hs     = s_arvalid & s_arready;
  assign r_last_hs = s_rvalid & s_rready & s_rlast;

`ifdef YSYX_23060124_ARB_RR_EN
  logic last_lsu;

  always_ff @(posedge clock) begin
    if (i_rst) begin
      last_lsu <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_lsu <= (state_nxt == GNT_LSU);
    end
  end

  assign both_to_lsu = ~last_lsu;
`else
  assign both_to_lsu = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (i_rst) begin
      state   <= IDLE;
      ar_done <= 1'b0;
      rid_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        ar_done <= 1'b0;
      end else if (ar_hs) begin
        ar_done <= 1'b1;
      end
      if (ar_hs) begin
        rid_q <= (state == GNT_LSU) ? lsu_arid : ifu_arid;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ifu_arvalid && lsu_arvalid) begin
          state_nxt = both_to_lsu ? GNT_LSU : GNT_IFU;
        end else if (lsu_arvalid) begin
          state_nxt = GNT_LSU;
        end else if (ifu_arvalid) begin
          state_nxt = GNT_IFU;
        end
      end
      GNT_IFU, GNT_LSU: begin
        if (r_last_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Once the single burst of a grant is accepted, AR is closed on both sides.
  always_comb begin
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_arid      = '0;
    s_arlen     = '0;
    s_arsize    = '0;
    s_arburst   = '0;
    s_rready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rvalid  = 1'b0;
    ifu_rid     = '0;
    ifu_rlast   = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rvalid  = 1'b0;
    lsu_rid     = '0;
    lsu_rlast   = 1'b0;
    unique case (state)
      GNT_IFU: begin
        s_araddr    = ifu_araddr;
        s_arvalid   = ifu_arvalid & ~ar_done;
        s_arid      = ID_IFU;
        s_arlen     = ifu_arlen;
        s_arsize    = ifu_arsize;
        s_arburst   = ifu_arburst;
        ifu_arready = s_arready & ~ar_done;
        ifu_rdata   = s_rdata;
        ifu_rresp   = s_rresp;
        ifu_rvalid  = s_rvalid;
        ifu_rid     = rid_q;
        ifu_rlast   = s_rlast;
        s_rready    = ifu_rready;
      end
      GNT_LSU: begin
        s_araddr    = lsu_araddr;
        s_arvalid   = lsu_arvalid & ~ar_done;
        s_arid      = ID_LSU;
        s_arlen     = lsu_arlen;
        s_arsize    = lsu_arsize;
        s_arburst   = lsu_arburst;
        lsu_arready = s_arready & ~ar_done;
        lsu_rdata   = s_rdata;
        lsu_rresp   = s_rresp;
        lsu_rvalid  = s_rvalid;
        lsu_rid     = rid_q;
        lsu_rlast   = s_rlast;
        s_rready    = lsu_rready;
      end
      default: begin
      end
    endcase
  end

  assign s_awaddr    = lsu_awaddr;
  assign s_awvalid   = lsu_awvalid;
  assign s_awlen     = lsu_awlen;
  assign s_awsize    = lsu_awsize;
  assign s_awburst   = lsu_awburst;
  assign lsu_awready = s_awready;
  assign s_wdata     = lsu_wdata;
  assign s_wstrb     = lsu_wstrb;
  assign s_wvalid    = lsu_wvalid;
  assign s_wlast     = lsu_wlast;
  assign lsu_wready  = s_wready;
  assign lsu_bresp   = s_bresp;
  assign lsu_bvalid  = s_bvalid;
  assign lsu_bid     = s_bid;
  assign s_bready    = lsu_bready;

endmodule
